// File: rtl/ocx_tlx_tx_vc0_fifo_ctl.sv
// ocx_tlx_tx_vc0_fifo_ctl: TX VC0 FIFO control; queues AFU entries into an external RAM and
// releases them in order only when partner VC0/DCP0 TL credits cover the head entry.
module ocx_tlx_tx_vc0_fifo_ctl #(
  parameter int addr_width = 7,
  parameter int DATA_WIDTH = 56
) (
  input  logic                  tlx_clk,
  input  logic                  reset,
  input  logic                  afu_cmd_valid,
  input  logic [DATA_WIDTH-1:0] afu_cmd_info,
  input  logic [1:0]            afu_cmd_dl,
  output logic [6:0]            tlx_afu_initial_credit,
  output logic                  tlx_afu_credit,
  output logic                  wr_ena,
  output logic [addr_width-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_ena,
  output logic [addr_width-1:0] rd_addr,
  input  logic                  rcv_tl_credit_valid,
  input  logic [3:0]            rcv_vc0_credit,
  input  logic [5:0]            rcv_dcp0_credit,
  input  logic                  fp_tx_ready,
  output logic                  fp_tx_valid,
  output logic [1:0]            fp_tx_dl,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  afu_overrun_err,
  output logic                  credit_overflow_err
);
  localparam int D = 1 << addr_width;
  localparam int IC = D > 127 ? 127 : D;
  logic [addr_width:0] r_wr_ptr, r_rd_ptr;
  logic [7:0]          r_vc0;
  logic [9:0]          r_dcp0;
  logic [1:0]          r_dl_mem [D];
  logic                r_valid, r_ovr, r_cov;
  logic [1:0]          r_dl;
  logic [1:0]          w_code;
  logic [2:0]          w_need;
  logic [8:0]          w_vc0_sum;
  logic [10:0]         w_dcp0_sum;
  assign tlx_afu_initial_credit = 7'(IC);
  assign wr_addr     = r_wr_ptr[addr_width-1:0];
  assign rd_addr     = r_rd_ptr[addr_width-1:0];
  assign fifo_empty  = r_wr_ptr == r_rd_ptr;
  assign fifo_full   = (wr_addr == rd_addr) & (r_wr_ptr[addr_width] != r_rd_ptr[addr_width]);
  assign wr_ena      = afu_cmd_valid & ~fifo_full & ~reset;
  assign wr_data     = afu_cmd_info;
  assign w_code      = r_dl_mem[rd_addr];
  assign w_need      = w_code == 2'b11 ? 3'd4 : {1'b0, w_code};
  assign rd_ena      = ~fifo_empty & fp_tx_ready & (r_vc0 != 8'd0) & (r_dcp0 >= 10'(w_need));
  // One extra bit of headroom lets saturation be detected after return and consume are both applied
  assign w_vc0_sum   = {1'b0, r_vc0} + (rcv_tl_credit_valid ? 9'(rcv_vc0_credit) : 9'd0) - 9'(rd_ena);
  assign w_dcp0_sum  = {1'b0, r_dcp0} + (rcv_tl_credit_valid ? 11'(rcv_dcp0_credit) : 11'd0)
                     - (rd_ena ? 11'(w_need) : 11'd0);
  assign tlx_afu_credit      = r_valid;
  assign fp_tx_valid         = r_valid;
  assign fp_tx_dl            = r_dl;
  assign afu_overrun_err     = r_ovr;
  assign credit_overflow_err = r_cov;
  always_ff @(posedge tlx_clk) begin
    if (wr_ena) r_dl_mem[wr_addr] <= afu_cmd_dl;
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_vc0    <= '0;
      r_dcp0   <= '0;
      r_valid  <= 1'b0;
      r_dl     <= 2'b00;
      r_ovr    <= 1'b0;
      r_cov    <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + (addr_width+1)'(wr_ena);
      r_rd_ptr <= r_rd_ptr + (addr_width+1)'(rd_ena);
      r_vc0    <= w_vc0_sum[8] ? 8'hff : w_vc0_sum[7:0];
      r_dcp0   <= w_dcp0_sum[10] ? 10'h3ff : w_dcp0_sum[9:0];
      r_valid  <= rd_ena;
      r_dl     <= rd_ena ? w_code : 2'b00;
      r_ovr    <= r_ovr | (afu_cmd_valid & fifo_full);
      r_cov    <= r_cov | w_vc0_sum[8] | w_dcp0_sum[10];
    end
  end
endmodule

// File: tb/tb_ocx_tlx_tx_vc0_fifo_ctl.sv
// tb_ocx_tlx_tx_vc0_fifo_ctl: directed and random stimulus against a queue-based model of the TX VC0 FIFO.
module tb_ocx_tlx_tx_vc0_fifo_ctl;
  localparam int AW = 7, DW = 56, D = 1 << AW;
  logic          tlx_clk = 1'b0, reset = 1'b1;
  logic          afu_cmd_valid = 1'b0;
  logic [DW-1:0] afu_cmd_info = '0;
  logic [1:0]    afu_cmd_dl = '0;
  logic          rcv_tl_credit_valid = 1'b0;
  logic [3:0]    rcv_vc0_credit = '0;
  logic [5:0]    rcv_dcp0_credit = '0;
  logic          fp_tx_ready = 1'b0;
  logic [6:0]    tlx_afu_initial_credit;
  logic          tlx_afu_credit, wr_ena, rd_ena, fp_tx_valid, fifo_empty, fifo_full;
  logic          afu_overrun_err, credit_overflow_err;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic [1:0]    fp_tx_dl;
  always #5 tlx_clk = ~tlx_clk;
  ocx_tlx_tx_vc0_fifo_ctl #(.addr_width(AW), .DATA_WIDTH(DW)) dut (
    .tlx_clk(tlx_clk), .reset(reset), .afu_cmd_valid(afu_cmd_valid), .afu_cmd_info(afu_cmd_info),
    .afu_cmd_dl(afu_cmd_dl), .tlx_afu_initial_credit(tlx_afu_initial_credit),
    .tlx_afu_credit(tlx_afu_credit), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_ena(rd_ena), .rd_addr(rd_addr), .rcv_tl_credit_valid(rcv_tl_credit_valid),
    .rcv_vc0_credit(rcv_vc0_credit), .rcv_dcp0_credit(rcv_dcp0_credit), .fp_tx_ready(fp_tx_ready),
    .fp_tx_valid(fp_tx_valid), .fp_tx_dl(fp_tx_dl), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .afu_overrun_err(afu_overrun_err), .credit_overflow_err(credit_overflow_err));
  logic [DW-1:0] ram [D];
  logic [DW-1:0] ram_q;
  always @(posedge tlx_clk) begin
    if (wr_ena) ram[wr_addr] <= wr_data;
    if (rd_ena) ram_q <= ram[rd_addr];
  end
  int n_cmp = 0, n_bad = 0;
  bit m_on = 0, m_ovr, m_cov, m_pv;
  int m_wp, m_rp, m_vc0, m_dcp0, m_pdl;
  logic [DW-1:0] m_pdata;
  int q_dl[$];
  logic [DW-1:0] q_data[$];
  function automatic int dec(int c);
    return c == 3 ? 4 : c;
  endfunction
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: dut=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_clear();
    m_wp = 0; m_rp = 0; m_vc0 = 0; m_dcp0 = 0; m_ovr = 0; m_cov = 0; m_pv = 0; m_pdl = 0;
    q_dl.delete(); q_data.delete();
  endtask
  always @(negedge tlx_clk) begin : cmp
    bit e_rd, e_wr, was_full;
    int need, n;
    if (m_on) begin
      need = q_dl.size() != 0 ? dec(q_dl[0]) : 0;
      was_full = q_dl.size() == D;
      e_rd = q_dl.size() != 0 && fp_tx_ready && m_vc0 != 0 && m_dcp0 >= need;
      e_wr = !reset && afu_cmd_valid && !was_full;
      chk("rd_ena", rd_ena, e_rd);
      chk("wr_ena", wr_ena, e_wr);
      chk("wr_addr", wr_addr, m_wp);
      chk("rd_addr", rd_addr, m_rp);
      if (e_wr) chk("wr_data", wr_data, afu_cmd_info);
      chk("fifo_empty", fifo_empty, q_dl.size() == 0);
      chk("fifo_full", fifo_full, was_full);
      chk("overrun_err", afu_overrun_err, m_ovr);
      chk("cov_err", credit_overflow_err, m_cov);
      chk("fp_tx_valid", fp_tx_valid, m_pv);
      chk("afu_credit", tlx_afu_credit, m_pv);
      chk("init_credit", tlx_afu_initial_credit, D > 127 ? 127 : D);
      if (m_pv) begin
        chk("fp_tx_dl", fp_tx_dl, m_pdl);
        chk("rd_data", ram_q, m_pdata);
      end
      if (reset) model_clear();
      else begin
        if (e_rd) begin
          m_pdl = q_dl.pop_front();
          m_pdata = q_data.pop_front();
          m_rp = (m_rp + 1) % D;
        end
        if (e_wr) begin
          q_dl.push_back(int'(afu_cmd_dl));
          q_data.push_back(afu_cmd_info);
          m_wp = (m_wp + 1) % D;
        end
        if (afu_cmd_valid && was_full) m_ovr = 1;
        n = m_vc0 + (rcv_tl_credit_valid ? int'(rcv_vc0_credit) : 0) - (e_rd ? 1 : 0);
        if (n > 255) begin n = 255; m_cov = 1; end
        m_vc0 = n;
        n = m_dcp0 + (rcv_tl_credit_valid ? int'(rcv_dcp0_credit) : 0) - (e_rd ? need : 0);
        if (n > 1023) begin n = 1023; m_cov = 1; end
        m_dcp0 = n;
        m_pv = e_rd;
      end
    end else if (reset) begin
      model_clear();
      m_on = 1;
    end
  end
  task automatic drive(bit r, bit v, int dl, bit ct, int rv, int rd, bit rdy);
    @(posedge tlx_clk);
    #1;
    reset = r;
    afu_cmd_valid = v;
    afu_cmd_dl = 2'(dl);
    afu_cmd_info = DW'({$urandom(), $urandom()});
    rcv_tl_credit_valid = ct;
    rcv_vc0_credit = 4'(rv);
    rcv_dcp0_credit = 6'(rd);
    fp_tx_ready = rdy;
    @(negedge tlx_clk);
  endtask
  initial begin
    bit done;
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    // Entries without partner credits must not leave; two VC0 credits release exactly two
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 0, 0, 1); chk("s1_blocked", rd_ena, 0); end
    drive(0, 0, 0, 1, 2, 0, 1); chk("s1_n_rd", rd_ena, 0);
    drive(0, 0, 0, 0, 0, 0, 1); chk("s1_n1_rd", rd_ena, 1); chk("s1_n1_val", fp_tx_valid, 0);
    drive(0, 0, 0, 0, 0, 0, 1); chk("s1_n2_rd", rd_ena, 1); chk("s1_n2_val", fp_tx_valid, 1);
    chk("s1_n2_cred", tlx_afu_credit, 1);
    drive(0, 0, 0, 0, 0, 0, 1); chk("s1_n3_rd", rd_ena, 0); chk("s1_n3_cred", tlx_afu_credit, 1);
    drive(0, 0, 0, 0, 0, 0, 1); chk("s1_n4_val", fp_tx_valid, 0);
    #1; chk("s1_m_vc0", m_vc0, 0); chk("s1_m_left", q_dl.size(), 1);
    // Head dl=4 with only 3 DCP0 credits blocks itself and the dl=0 entry behind it
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 3, 1, 5, 3, 1);
    drive(0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 0, 0, 1); chk("s2_blocked", rd_ena, 0); end
    drive(0, 0, 0, 1, 0, 1, 1); chk("s2_n_rd", rd_ena, 0);
    drive(0, 0, 0, 0, 0, 0, 1); chk("s2_n1_rd", rd_ena, 1);
    drive(0, 0, 0, 0, 0, 0, 0); chk("s2_dl", fp_tx_dl, 3); chk("s2_val", fp_tx_valid, 1);
    #1; chk("s2_m_dcp0", m_dcp0, 0); chk("s2_m_vc0", m_vc0, 4);
    // Fill to full, overrun, then drain through the wrap with random credits and ready
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < D; i++) drive(0, 1, $urandom_range(0, 3), 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0); chk("s3_full", fifo_full, 1); chk("s3_wr_ena", wr_ena, 0);
    chk("s3_wr_addr", wr_addr, 0);
    drive(0, 0, 0, 0, 0, 0, 0); chk("s3_overrun", afu_overrun_err, 1); chk("s3_wr_addr2", wr_addr, 0);
    done = 0;
    for (int i = 0; i < 4000 && !done; i++) begin
      drive(0, 0, 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15), $urandom_range(0, 63),
            $urandom_range(0, 3) != 0);
      done = fifo_empty;
    end
    chk("s3_drained", done, 1);
    chk("s3_m_empty", q_dl.size(), 0);
    // Pop needing 2 while vc0=1/dcp0=4 arrive in the same cycle
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 2, 1, 1, 2, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 4, 1); chk("s4_rd", rd_ena, 1);
    #1; chk("s4_m_vc0", m_vc0, 1); chk("s4_m_dcp0", m_dcp0, 4);
    drive(0, 0, 0, 0, 0, 0, 0); chk("s4_dl", fp_tx_dl, 2);
    // VC0 saturation, then reset in the middle of traffic
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++) drive(0, 0, 0, 1, 15, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0); chk("s5_cov", credit_overflow_err, 1);
    #1; chk("s5_m_vc0", m_vc0, 255);
    drive(0, 0, 0, 1, 0, 63, 0);
    for (int i = 0; i < 6; i++) drive(0, 1, $urandom_range(0, 3), 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("s5_r_cred", tlx_afu_credit, 0); chk("s5_r_wr", wr_ena, 0); chk("s5_r_rd", rd_ena, 0);
    chk("s5_r_val", fp_tx_valid, 0); chk("s5_r_dl", fp_tx_dl, 0); chk("s5_r_full", fifo_full, 0);
    chk("s5_r_empty", fifo_empty, 1); chk("s5_r_ovr", afu_overrun_err, 0);
    chk("s5_r_cov", credit_overflow_err, 0); chk("s5_r_wa", wr_addr, 0); chk("s5_r_ra", rd_addr, 0);
    chk("s5_r_ic", tlx_afu_initial_credit, 127);
    // Mixed random traffic, with occasional resets
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 499) == 0, $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 4) == 0, $urandom_range(0, 15), $urandom_range(0, 63),
            $urandom_range(0, 9) < 7);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ocx_tlx_tx_vc0_fifo_ctl.md
# ocx_tlx_tx_vc0_fifo_ctl

Transmit-side VC0 FIFO controller for the host TLX. It queues VC0 commands/responses from the AFU into an external two-port RAM and returns one AFU credit per freed entry. It releases entries to the flit framer only when the link partner has returned enough VC0 and DCP0 TL credits. It is the transmit counterpart of the receive-side VC0 FIFO control and sits between the AFU command interface and the TX framer.

## Interface
Parameters:
- addr_width, 7, log2 of FIFO depth; depth D = 2^addr_width.
- DATA_WIDTH, 56, command/response info width.

Ports:
- tlx_clk  in  1  sole clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- afu_cmd_valid  in  1  push one entry this cycle.
- afu_cmd_info  in  DATA_WIDTH  entry payload.
- afu_cmd_dl  in  2  data flits owed by entry: 00=0, 01=1, 10=2, 11=4.
- tlx_afu_initial_credit  out  7  constant min(D,127).
- tlx_afu_credit  out  1  one-cycle pulse; one AFU credit returned.
- wr_ena  out  1  RAM write enable.
- wr_addr  out  addr_width  RAM write address.
- wr_data  out  DATA_WIDTH  RAM write data.
- rd_ena  out  1  RAM read enable, which is also the pop strobe.
- rd_addr  out  addr_width  RAM read address.
- rcv_tl_credit_valid  in  1  return_tl_credits received from the partner.
- rcv_vc0_credit  in  4  VC0 credits returned.
- rcv_dcp0_credit  in  6  DCP0 data credits returned.
- fp_tx_ready  in  1  framer accepts an entry this cycle.
- fp_tx_valid  out  1  RAM read data valid for framer.
- fp_tx_dl  out  2  dl of the entry presented with fp_tx_valid.
- fifo_empty, fifo_full  out  1 each  registered status.
- afu_overrun_err  out  1  sticky; push while full.
- credit_overflow_err  out  1  sticky; partner credit counter saturated.

## Operation
- Pointers: wr_ptr and rd_ptr are each addr_width+1 bits, and the MSB is the wrap bit. wr_addr and rd_addr are pointer[addr_width-1:0].
  - empty: pointers equal.
  - full: low bits equal and wrap bits differ.
- Push: wr_ena = afu_cmd_valid & ~full, and wr_data = afu_cmd_info.
  - wr_ptr increments by 1 on each push.
  - afu_cmd_dl is stored in an internal D x 2 sideband array at wr_addr.
  - A push while full is dropped: no pointer change, and afu_overrun_err is set.
- Partner credit counters reset to 0; credits arrive only via return_tl_credits.
  - vc0_cnt: 8 bits.
  - dcp0_cnt: 10 bits.
- Head data need: need = decode(sideband[rd_addr]), with decode 0/1/2/4.
- Pop: rd_ena = ~empty & fp_tx_ready & (vc0_cnt != 0) & (dcp0_cnt >= need). This is combinational from registered state plus fp_tx_ready.
  - rd_ptr increments by 1.
  - vc0_cnt decreases by 1.
  - dcp0_cnt decreases by need.
- Credit update each cycle: cnt_next = cnt + (rcv_tl_credit_valid ? returned : 0) - consumed, computed at width+1.
  - If the result exceeds max (255 / 1023), the counter loads max and credit_overflow_err is set.
  - Return and consume in the same cycle are both applied.
- Strict in-order service: a head entry blocked on DCP0 blocks all later entries, including dl=0 entries.
- Reset mid-operation: pointers, counters, sideband-valid state, pipeline flops and error flags all clear on the next edge. RAM contents are don't-care.

## Timing
- Reset values:
  - 0: tlx_afu_credit, wr_ena, rd_ena, fp_tx_valid, fp_tx_dl, fifo_full, errors, rd_addr, wr_addr.
  - 1: fifo_empty.
  - tlx_afu_initial_credit: constant.
- Push at cycle N is poppable at cycle N+1 at the earliest. There is no write-to-read bypass.
- RAM read latency is 1 cycle.
  - fp_tx_valid and fp_tx_dl are rd_ena and need-code registered once, so they align with RAM data at N+1.
  - tlx_afu_credit is the same registered pulse as fp_tx_valid, one pulse per pop.
- Credits returned at cycle N are usable for a pop at N+1.
- Sustained throughput is 1 pop per cycle when credits and ready allow.
- Full/empty wrap: after D pushes with no pops, full=1 and the wrap bits differ. Pointer wrap past D-1 to 0 is seamless.

## Test plan
- After reset, push 3 entries with dl=00 and hold fp_tx_ready=1 with no partner credits.
  - Required: no rd_ena.
  - Then return vc0=2 at cycle N: rd_ena at N+1 and N+2, fp_tx_valid and tlx_afu_credit at N+2 and N+3, and vc0_cnt=0 with one entry left.
- Head entry dl=11, vc0=5, dcp0=3.
  - Required: blocked, no pop.
  - Then return dcp0=1: pop next cycle, dcp0_cnt=0, vc0_cnt=4, fp_tx_dl=11.
- Push D entries with no credits: fifo_full=1 after D pushes.
  - Required: a further push gives wr_ena=0 and afu_overrun_err=1, with wr_ptr unchanged.
  - Then drain all entries: the pointers wrap to empty with correct order of wr_data.
- Simultaneous pop (need=2) and return (vc0=1, dcp0=4) with vc0_cnt=1 and dcp0_cnt=2.
  - Required next: vc0_cnt=1, dcp0_cnt=4.
- Return vc0=15 repeatedly until 255 is exceeded.
  - Required: vc0_cnt=255 and credit_overflow_err=1.
  - Then assert reset mid-stream: all outputs reach reset values on the next edge.
